score_bcd_accum: RTL and testbench

Game-side score keeper that feeds the 4-digit seven-segment score display.
- Accepts line-clear events from the playfield logic.
- Looks up a BCD point value for 1..4 lines and scales it by the current level through repeated digit-serial BCD addition.
- Drives a packed 4-digit BCD score (one nibble per displayed digit) that saturates at 9999.
- The score output changes only on commit, so the display never shows a partial sum.

---
 rtl/score_bcd_accum.sv | 123 ++++++++++++
 tb/tb_score_bcd_accum.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_accum.sv
// Score keeper: scales a BCD point value by the level with digit-serial BCD
// addition and publishes the 4-digit score (saturating at 9999) on commit.
module score_bcd_accum #(
    parameter logic [15:0] P1        = 16'h0001,
    parameter logic [15:0] P2        = 16'h0003,
    parameter logic [15:0] P3        = 16'h0005,
    parameter logic [15:0] P4        = 16'h0008,
    parameter int          MAX_LEVEL = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        clear_valid,
    output logic        clear_ready,
    input  logic [2:0]  clear_lines,
    input  logic [3:0]  level,
    output logic [15:0] score,
    output logic        score_update,
    output logic        saturated
);

    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_LEVEL);

    state_t          state;
    logic [3:0][3:0] acc;
    logic [3:0][3:0] add;
    logic [3:0]      passes;
    logic [1:0]      d;
    logic            carry;

    logic [4:0] nib_sum;
    logic [3:0] nib_new;
    logic       nib_carry;
    logic       lines_ok;
    logic [15:0] pts;
    logic [3:0]  lvl_clamped;

    // One BCD digit of the working sum; inputs are valid BCD so nib_sum <= 19.
    always_comb begin
        nib_sum   = {1'b0, acc[d]} + {1'b0, add[d]} + {4'd0, carry};
        nib_carry = (nib_sum > 5'd9);
        nib_new   = nib_carry ? 4'(nib_sum - 5'd10) : nib_sum[3:0];
    end

    always_comb begin
        lines_ok = 1'b1;
        pts      = 16'h0000;
        case (clear_lines)
            3'd1:    pts = P1;
            3'd2:    pts = P2;
            3'd3:    pts = P3;
            3'd4:    pts = P4;
            default: lines_ok = 1'b0;
        endcase
        if (level == 4'd0)
            lvl_clamped = 4'd1;
        else if (level > MAX_L)
            lvl_clamped = MAX_L;
        else
            lvl_clamped = level;
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state        <= IDLE;
            score        <= 16'h0000;
            acc          <= '0;
            add          <= '0;
            passes       <= 4'd0;
            d            <= 2'd0;
            carry        <= 1'b0;
            score_update <= 1'b0;
            saturated    <= 1'b0;
            clear_ready  <= 1'b1;
        end else begin
            score_update <= 1'b0;
            case (state)
                IDLE: begin
                    // Illegal line counts are consumed here without effect.
                    if (clear_valid && lines_ok) begin
                        add         <= pts;
                        passes      <= lvl_clamped;
                        acc         <= score;
                        d           <= 2'd0;
                        carry       <= 1'b0;
                        clear_ready <= 1'b0;
                        state       <= ADD;
                    end
                end
                ADD: begin
                    acc[d] <= nib_new;
                    carry  <= nib_carry;
                    d      <= d + 2'd1;
                    if (d == 2'd3) begin
                        carry <= 1'b0;
                        if (nib_carry) begin
                            acc   <= 16'h9999;
                            state <= COMMIT;
                        end else if (passes == 4'd1) begin
                            state <= COMMIT;
                        end else begin
                            passes <= passes - 4'd1;
                        end
                    end
                end
                COMMIT: begin
                    score        <= acc;
                    saturated    <= (acc == 16'h9999);
                    score_update <= 1'b1;
                    clear_ready  <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    clear_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Bench for score_bcd_accum: directed scenarios plus random events against a
// decimal-integer score model.
module tb_score_bcd_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        clear_valid;
    logic        clear_ready;
    logic [2:0]  clear_lines;
    logic [3:0]  level;
    logic [15:0] score;
    logic        score_update;
    logic        saturated;

    int n_vec  = 0;
    int n_fail = 0;
    int model  = 0;

    score_bcd_accum dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .clear_valid  (clear_valid),
        .clear_ready  (clear_ready),
        .clear_lines  (clear_lines),
        .level        (level),
        .score        (score),
        .score_update (score_update),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Present one event; when noise is set, clear_valid is pulsed while busy.
    task automatic do_event(input int lines, input int lvl, input bit noise);
        int w, p, lpass, pts;
        bit changed, busy_ready;
        logic [15:0] old;
        int pts_tab[4] = '{1, 3, 5, 8};
        clear_valid = 1'b1;
        clear_lines = 3'(lines);
        level       = 4'(lvl);
        w = 0;
        while (!clear_ready && w < 100) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(w < 100), 32'd1);
        old = score;
        tick();
        clear_valid = 1'b0;
        if (lines < 1 || lines > 4) begin
            changed = 0;
            for (int i = 0; i < 4; i++) begin
                if (score_update || !clear_ready || score != old) changed = 1;
                tick();
            end
            chk("illegal_noeffect", 32'(changed), 32'd0);
            chk("illegal_score", 32'(score), 32'(to_bcd(model)));
            return;
        end
        pts   = pts_tab[lines - 1];
        lpass = (lvl == 0) ? 1 : (lvl > 9 ? 9 : lvl);
        p = 0;
        for (int i = 0; i < lpass; i++) begin
            p++;
            model += pts;
            if (model > 9999) begin
                model = 9999;
                break;
            end
        end
        w = 0;
        changed = 0;
        busy_ready = 0;
        while (!score_update && w < 200) begin
            if (noise && w == 1) begin
                clear_valid = 1'b1;
                clear_lines = 3'd4;
            end else begin
                clear_valid = 1'b0;
            end
            if (clear_ready) busy_ready = 1;
            tick();
            w++;
            if (!score_update && score != old) changed = 1;
        end
        clear_valid = 1'b0;
        chk("latency", 32'(w), 32'(4 * p + 1));
        chk("busy_ready_low", 32'(busy_ready), 32'd0);
        chk("no_partial", 32'(changed), 32'd0);
        chk("score", 32'(score), 32'(to_bcd(model)));
        chk("saturated", 32'(saturated), 32'(model == 9999));
        chk("ready_back", 32'(clear_ready), 32'd1);
        tick();
        chk("pulse_once", 32'(score_update), 32'd0);
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model = 0;
        chk("ng_score", 32'(score), 32'h0);
        chk("ng_update", 32'(score_update), 32'd0);
        chk("ng_ready", 32'(clear_ready), 32'd1);
        chk("ng_sat", 32'(saturated), 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; new_game = 1'b0; clear_valid = 1'b1;
        clear_lines = 3'd1; level = 4'd1;
        repeat (2) tick();
        chk("rst_score", 32'(score), 32'h0);
        chk("rst_ready", 32'(clear_ready), 32'd1);
        chk("rst_update", 32'(score_update), 32'd0);
        chk("rst_sat", 32'(saturated), 32'd0);
        rst = 1'b0;
        clear_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (score_update || !clear_ready) seen = 1;
        end
        chk("rst_no_accept", 32'(seen), 32'd0);

        do_event(4, 1, 0);
        do_new_game();
        do_event(4, 9, 0);
        do_event(3, 4, 0);
        do_event(2, 1, 0);
        chk("reach_0095", 32'(score), 32'h0095);
        do_event(2, 3, 0);
        chk("score_0104", 32'(score), 32'h0104);

        for (int i = 0; i < 137; i++) do_event(4, 9, 0);
        do_event(2, 9, 0);
        chk("reach_9995", 32'(score), 32'h9995);
        do_event(4, 2, 0);
        chk("sat_9999", 32'(score), 32'h9999);
        chk("sat_flag", 32'(saturated), 32'd1);
        do_event(1, 1, 0);

        // Abort an add three cycles in.
        clear_valid = 1'b1; clear_lines = 3'd1; level = 4'd5;
        tick();
        clear_valid = 1'b0;
        tick(); tick();
        do_new_game();
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (score_update || score != 16'h0) seen = 1;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        do_event(1, 0, 0);
        chk("lvl0_score", 32'(score), 32'h0001);

        do_new_game();
        do_event(2, 2, 1);
        do_event(0, 3, 0);
        do_event(6, 3, 0);
        do_new_game();
        do_event(1, 12, 0);
        chk("clamp_9", 32'(score), 32'h0009);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) do_new_game();
            do_event(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
